// File: rtl/motor_cmd_pkg.sv
// Shared types and defaults for the motor command scheduler.
package motor_cmd_pkg;

  localparam int unsigned NumReq = 3;

  // Requester indices; lower index wins arbitration.
  localparam int unsigned ReqEstop  = 0;
  localparam int unsigned ReqNav    = 1;
  localparam int unsigned ReqManual = 2;

  localparam int unsigned SpeedWDefault          = 9;
  localparam int unsigned HeartbeatCyclesDefault = 25_000_000;
  localparam int unsigned AcceptTimeoutDefault   = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitAccept,
    StWaitDone
  } state_e;

endpackage

// File: rtl/fixed_priority_arbiter.sv
// Fixed-priority one-hot arbiter: the lowest set request bit wins.
module fixed_priority_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + N'(1));

endmodule

// File: rtl/motor_command_scheduler.sv
// Arbitrates wheel-speed requesters onto a single frame sender, with a heartbeat
// re-send of the last command and a sticky accept-timeout flag.
module motor_command_scheduler
  import motor_cmd_pkg::*;
#(
  parameter int unsigned SPEED_W          = SpeedWDefault,
  parameter int unsigned HEARTBEAT_CYCLES = HeartbeatCyclesDefault,
  parameter int unsigned ACCEPT_TIMEOUT   = AcceptTimeoutDefault
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NumReq-1:0]                      req,
  input  logic signed [NumReq-1:0][SPEED_W-1:0]  left_in,
  input  logic signed [NumReq-1:0][SPEED_W-1:0]  right_in,
  output logic [NumReq-1:0]                      grant,
  input  logic                                   sender_ready,
  output logic                                   cmd_start,
  output logic signed [SPEED_W-1:0]              cmd_left,
  output logic signed [SPEED_W-1:0]              cmd_right,
  output logic                                   busy,
  output logic                                   heartbeat_sent,
  output logic                                   timeout_err
);

  localparam int unsigned HbW  = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam int unsigned AccW = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;
  localparam logic [HbW-1:0]  HbMax  = HbW'(HEARTBEAT_CYCLES - 1);
  localparam logic [AccW-1:0] AccMax = AccW'(ACCEPT_TIMEOUT - 1);

  state_e             state_q;
  logic [HbW-1:0]     hb_cnt_q;
  logic [AccW-1:0]    acc_cnt_q;
  logic               hb_pend_q;
  logic [NumReq-1:0]  arb_grant;
  logic [SPEED_W-1:0] sel_left;
  logic [SPEED_W-1:0] sel_right;
  logic               hb_expired;

  fixed_priority_arbiter #(
    .N(NumReq)
  ) u_arb (
    .req  (req),
    .grant(arb_grant)
  );

  // One-hot payload mux driven by the arbiter grant.
  always_comb begin
    sel_left  = '0;
    sel_right = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (arb_grant[i]) begin
        sel_left  = left_in[i];
        sel_right = right_in[i];
      end
    end
  end

  assign hb_expired = (hb_cnt_q == HbMax);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      hb_cnt_q       <= '0;
      acc_cnt_q      <= '0;
      hb_pend_q      <= 1'b0;
      grant          <= '0;
      cmd_start      <= 1'b0;
      cmd_left       <= '0;
      cmd_right      <= '0;
      busy           <= 1'b0;
      heartbeat_sent <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      grant          <= '0;
      cmd_start      <= 1'b0;
      heartbeat_sent <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if ((req != '0) && sender_ready) begin
            grant     <= arb_grant;
            cmd_left  <= sel_left;
            cmd_right <= sel_right;
            hb_pend_q <= 1'b0;
            hb_cnt_q  <= '0;
            busy      <= 1'b1;
            state_q   <= StIssue;
          end else if (hb_expired && (req == '0) && sender_ready) begin
            hb_pend_q <= 1'b1;
            hb_cnt_q  <= '0;
            busy      <= 1'b1;
            state_q   <= StIssue;
          end else if (!hb_expired) begin
            // Saturates at expiry so a busy sender delays rather than loses the heartbeat.
            hb_cnt_q <= hb_cnt_q + HbW'(1);
          end
        end
        StIssue: begin
          cmd_start      <= 1'b1;
          heartbeat_sent <= hb_pend_q;
          hb_cnt_q       <= '0;
          acc_cnt_q      <= '0;
          state_q        <= StWaitAccept;
        end
        StWaitAccept: begin
          if (!sender_ready) begin
            state_q <= StWaitDone;
          end else if (acc_cnt_q == AccMax) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end else begin
            acc_cnt_q <= acc_cnt_q + AccW'(1);
          end
        end
        StWaitDone: begin
          if (sender_ready) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_command_scheduler.sv
// Self-checking bench: timestamp-based reference model plus directed literal checks
// and randomized requesters/sender.
module tb_motor_command_scheduler;

  localparam int SW  = 9;
  localparam int HB  = 16;
  localparam int ACC = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [2:0]           req;
  logic [2:0][SW-1:0]   left_in;
  logic [2:0][SW-1:0]   right_in;
  logic [2:0]           grant;
  logic                 sender_ready;
  logic                 cmd_start;
  logic signed [SW-1:0] cmd_left;
  logic signed [SW-1:0] cmd_right;
  logic                 busy;
  logic                 heartbeat_sent;
  logic                 timeout_err;

  int checks = 0;
  int failures = 0;

  motor_command_scheduler #(
    .SPEED_W         (SW),
    .HEARTBEAT_CYCLES(HB),
    .ACCEPT_TIMEOUT  (ACC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .left_in       (left_in),
    .right_in      (right_in),
    .grant         (grant),
    .sender_ready  (sender_ready),
    .cmd_start     (cmd_start),
    .cmd_left      (cmd_left),
    .cmd_right     (cmd_right),
    .busy          (busy),
    .heartbeat_sent(heartbeat_sent),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames are tracked by the edge they were issued on.
  int  edge_n = 0;
  bit  m_frame = 0;
  bit  m_hb_frame = 0;
  bit  m_tmo = 0;
  int  m_issue = 0;
  int  m_accept = -1;
  int  m_idle = 0;
  logic [2:0]           e_grant = '0;
  bit                   e_cs = 0;
  bit                   e_hbs = 0;
  logic signed [SW-1:0] e_l = '0;
  logic signed [SW-1:0] e_r = '0;

  task automatic model_step();
    int win;
    int k;
    e_grant = '0;
    e_cs    = 0;
    e_hbs   = 0;
    if (!rst_n) begin
      m_frame = 0;
      m_tmo   = 0;
      m_idle  = 0;
      e_l     = '0;
      e_r     = '0;
    end else if (!m_frame) begin
      if (req != 0 && sender_ready) begin
        win = 0;
        for (int i = 2; i >= 0; i--) if (req[i]) win = i;
        e_grant    = 3'(1 << win);
        e_l        = left_in[win];
        e_r        = right_in[win];
        m_frame    = 1;
        m_hb_frame = 0;
        m_issue    = edge_n;
        m_accept   = -1;
      end else if (req == 0 && sender_ready && m_idle >= HB - 1) begin
        m_frame    = 1;
        m_hb_frame = 1;
        m_issue    = edge_n;
        m_accept   = -1;
      end else begin
        m_idle++;
      end
    end else begin
      k = edge_n - m_issue;
      if (k == 1) begin
        e_cs  = 1;
        e_hbs = m_hb_frame;
      end else if (m_accept < 0) begin
        if (!sender_ready) m_accept = edge_n;
        else if (k - 1 >= ACC) begin
          m_tmo   = 1;
          m_frame = 0;
          m_idle  = 0;
        end
      end else if (sender_ready) begin
        m_frame = 0;
        m_idle  = 0;
      end
    end
    edge_n++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("m_grant", int'(grant), int'(e_grant));
      chk("m_cmd_start", int'(cmd_start), int'(e_cs));
      chk("m_heartbeat_sent", int'(heartbeat_sent), int'(e_hbs));
      chk("m_busy", int'(busy), int'(m_frame));
      chk("m_timeout_err", int'(timeout_err), int'(m_tmo));
      chk("m_cmd_left", int'(cmd_left), int'(e_l));
      chk("m_cmd_right", int'(cmd_right), int'(e_r));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  int s_phase = 0;
  int s_cnt = 0;

  initial begin
    int n;
    logic [2:0] g_seen;
    bit quiet;
    rst_n = 0; req = '0; sender_ready = 1; left_in = '0; right_in = '0;
    repeat (2) tick();
    chk("reset_grant", int'(grant), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cmd_left", int'(cmd_left), 0);
    chk("reset_timeout", int'(timeout_err), 0);

    // Navigation beats manual.
    rst_n = 1; left_in[1] = 9'd37; right_in[1] = 9'(-5); left_in[2] = 9'd100;
    req = 3'b110;
    tick();
    chk("nav_grant", int'(grant), 2);
    chk("nav_left", int'(cmd_left), 37);
    chk("nav_right", int'(cmd_right), -5);
    chk("nav_no_start_yet", int'(cmd_start), 0);
    req = 3'b100;
    tick();
    chk("nav_cmd_start", int'(cmd_start), 1);
    sender_ready = 0;
    tick();

    // E-stop arrives mid-frame; must wait for the frame and win over manual.
    left_in[0] = '0; right_in[0] = '0; req = 3'b101;
    repeat (3) begin
      tick();
      chk("estop_no_abort", int'(cmd_start), 0);
    end
    sender_ready = 1;
    tick();
    tick();
    chk("estop_grant", int'(grant), 1);
    chk("estop_left", int'(cmd_left), 0);
    req = 3'b100;
    tick();
    sender_ready = 0; tick();
    sender_ready = 1; tick();
    tick();
    chk("manual_grant", int'(grant), 4);
    req = 3'b000;
    tick();
    sender_ready = 0; tick();
    sender_ready = 1; tick();

    // Heartbeat after 16 idle cycles, same payload, no grant.
    n = 0; g_seen = '0;
    do begin
      tick(); n++; g_seen |= grant;
    end while (!heartbeat_sent && n < 40);
    chk("hb_latency", n, 17);
    chk("hb_cmd_start", int'(cmd_start), 1);
    chk("hb_payload", int'(cmd_left), 100);
    chk("hb_no_grant", int'(g_seen), 0);
    sender_ready = 0; tick();
    sender_ready = 1; tick();

    // Request on the expiry cycle wins.
    repeat (15) tick();
    left_in[2] = 9'(-77); req = 3'b100;
    tick();
    chk("tie_grant", int'(grant), 4);
    chk("tie_hb", int'(heartbeat_sent), 0);
    chk("tie_left", int'(cmd_left), -77);
    req = 3'b000;
    tick();
    chk("tie_start_not_hb", int'(heartbeat_sent), 0);
    sender_ready = 0; tick();
    sender_ready = 1; tick();

    // Saturated counter fires on the first ready idle cycle.
    sender_ready = 0;
    repeat (25) tick();
    chk("sat_idle", int'(busy), 0);
    sender_ready = 1;
    tick();
    tick();
    chk("sat_hb", int'(heartbeat_sent), 1);
    sender_ready = 0; tick();
    sender_ready = 1; tick();

    // Accept timeout.
    req = 3'b010;
    tick();
    req = 3'b000;
    tick();
    n = 0;
    do begin
      tick(); n++;
    end while (!timeout_err && n < 30);
    chk("tmo_latency", n, 8);
    chk("tmo_idle", int'(busy), 0);
    repeat (3) tick();
    chk("tmo_sticky", int'(timeout_err), 1);

    // Reset mid-frame.
    left_in[0] = 9'd12; req = 3'b001;
    tick();
    req = 3'b000;
    tick();
    sender_ready = 0;
    tick();
    rst_n = 0;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_left", int'(cmd_left), 0);
    chk("rst_start", int'(cmd_start), 0);
    chk("rst_timeout", int'(timeout_err), 0);
    rst_n = 1; sender_ready = 1;
    n = 0;
    repeat (10) begin
      tick(); n += int'(cmd_start);
    end
    chk("rst_no_spurious", n, 0);

    // Randomized requesters and sender.
    for (int c = 0; c < 4000; c++) begin
      tick();
      quiet = ((c / 150) % 2) == 1;
      for (int i = 0; i < 3; i++) begin
        if (req[i]) begin
          if (grant[i]) req[i] = 1'b0;
        end else if ((!quiet && $urandom_range(7) == 0) ||
                     (quiet && i == 0 && $urandom_range(300) == 0)) begin
          req[i]      = 1'b1;
          left_in[i]  = 9'($urandom);
          right_in[i] = 9'($urandom);
        end
      end
      case (s_phase)
        0: begin
          if (cmd_start && $urandom_range(9) != 0) begin
            s_phase = 1; s_cnt = $urandom_range(2);
          end else if (!cmd_start && $urandom_range(29) == 0) begin
            sender_ready = 0; s_phase = 2; s_cnt = $urandom_range(20, 1);
          end
        end
        1: begin
          if (s_cnt == 0) begin
            sender_ready = 0; s_phase = 2; s_cnt = $urandom_range(6, 1);
          end else s_cnt--;
        end
        default: begin
          if (s_cnt == 0) begin
            sender_ready = 1; s_phase = 0;
          end else s_cnt--;
        end
      endcase
      rst_n = ($urandom_range(999) != 0);
    end
    rst_n = 1;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
